// File: rtl/sha256_nonce_driver.sv
// sha256_nonce_driver
//   Nonce-sweep job initiator for the start/done SHA-256 engine. For every
//   nonce in [nonce_start, nonce_end] (inclusive, 32-bit wrapping), it:
//   writes the nonce into the message template, pulses eng_start, waits for
//   eng_done (with timeout), reads the 8-word digest back and compares
//   digest word 0 against the target. The job stops on the first hit, on an
//   abort, on range exhaustion or on an engine timeout.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   job_start/job_abort : host control (start sampled in IDLE only)
//   nonce_start/_end    : inclusive nonce range, target : hit threshold
//   busy, job_done      : job status, job_done is a one-cycle pulse
//   found/timeout_err/aborted, result_nonce/result_hash/attempts : results
//   eng_*               : engine handshake and constant buffer addresses
//   mem_*               : shared memory port (granted externally via mem_own)
module sha256_nonce_driver #(
  parameter logic [15:0] MSG_ADDR       = 16'h0000,
  parameter logic [15:0] OUT_ADDR       = 16'h0100,
  parameter int unsigned NONCE_IDX      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_start,
  input  logic         job_abort,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [31:0]  target,
  output logic         busy,
  output logic         job_done,
  output logic         found,
  output logic         timeout_err,
  output logic         aborted,
  output logic [31:0]  result_nonce,
  output logic [255:0] result_hash,
  output logic [31:0]  attempts,
  output logic         eng_start,
  output logic [15:0]  eng_message_addr,
  output logic [15:0]  eng_output_addr,
  input  logic         eng_done,
  output logic         mem_own,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  output logic [31:0]  mem_write_data,
  input  logic [31:0]  mem_read_data
);

  localparam int unsigned CW         = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] NONCE_ADDR = MSG_ADDR + 16'(NONCE_IDX);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_START, S_WAIT, S_READ, S_CHECK, S_DONE
  } state_t;

  state_t        state_q;
  logic [31:0]   nonce_q, end_q, target_q;
  logic          abort_pend_q;
  logic [CW-1:0] wait_cnt_q;
  logic [3:0]    rd_cnt_q;
  logic [31:0]   digest_q [8];
  logic          busy_q, job_done_q, found_q, timeout_q, aborted_q;
  logic [31:0]   result_nonce_q, attempts_q;
  logic [255:0]  result_hash_q;
  logic          eng_start_q, mem_own_q, mem_we_q;
  logic [15:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [255:0]  digest_d;
  logic [31:0]   nonce_d;

  // Word 0 lands in the top 32 bits of the flattened digest.
  for (genvar gi = 0; gi < 8; gi++) begin : g_flat
    assign digest_d[255-32*gi -: 32] = digest_q[gi];
  end

  assign nonce_d = nonce_q + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      nonce_q        <= '0;
      end_q          <= '0;
      target_q       <= '0;
      abort_pend_q   <= 1'b0;
      wait_cnt_q     <= '0;
      rd_cnt_q       <= '0;
      for (int i = 0; i < 8; i++) digest_q[i] <= '0;
      busy_q         <= 1'b0;
      job_done_q     <= 1'b0;
      found_q        <= 1'b0;
      timeout_q      <= 1'b0;
      aborted_q      <= 1'b0;
      result_nonce_q <= '0;
      result_hash_q  <= '0;
      attempts_q     <= '0;
      eng_start_q    <= 1'b0;
      mem_own_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
    end else begin
      eng_start_q <= 1'b0;
      job_done_q  <= 1'b0;
      if (busy_q && job_abort) abort_pend_q <= 1'b1;

      // Outputs are registered: each transition sets what the next state drives.
      case (state_q)
        S_IDLE: begin
          if (job_start) begin
            nonce_q      <= nonce_start;
            end_q        <= nonce_end;
            target_q     <= target;
            found_q      <= 1'b0;
            timeout_q    <= 1'b0;
            aborted_q    <= 1'b0;
            attempts_q   <= '0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b1;
            mem_own_q    <= 1'b1;
            mem_we_q     <= 1'b1;
            mem_addr_q   <= NONCE_ADDR;
            mem_wdata_q  <= nonce_start;
            state_q      <= S_WRITE;
          end
        end
        S_WRITE: begin
          mem_own_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          eng_start_q <= 1'b1;
          state_q     <= S_START;
        end
        S_START: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            rd_cnt_q   <= '0;
            mem_own_q  <= 1'b1;
            mem_addr_q <= OUT_ADDR;
            state_q    <= S_READ;
          end else if (wait_cnt_q == WAIT_LAST) begin
            timeout_q  <= 1'b1;
            job_done_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_READ: begin
          // Read data trails the address by one cycle, so cycle r stores word r-1.
          if (rd_cnt_q != 4'd0) digest_q[rd_cnt_q[2:0] - 3'd1] <= mem_read_data;
          if (rd_cnt_q == 4'd8) begin
            mem_own_q  <= 1'b0;
            mem_addr_q <= '0;
            state_q    <= S_CHECK;
          end else begin
            rd_cnt_q   <= rd_cnt_q + 4'd1;
            mem_addr_q <= (rd_cnt_q == 4'd7) ? 16'h0000
                                             : OUT_ADDR + 16'(rd_cnt_q) + 16'd1;
          end
        end
        S_CHECK: begin
          attempts_q     <= attempts_q + 32'd1;
          result_nonce_q <= nonce_q;
          result_hash_q  <= digest_d;
          if (digest_q[0] < target_q) begin
            found_q    <= 1'b1;
            job_done_q <= 1'b1;
            state_q    <= S_DONE;
          end else if (abort_pend_q) begin
            aborted_q  <= 1'b1;
            job_done_q <= 1'b1;
            state_q    <= S_DONE;
          end else if (nonce_q == end_q) begin
            job_done_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            nonce_q     <= nonce_d;
            mem_own_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= NONCE_ADDR;
            mem_wdata_q <= nonce_d;
            state_q     <= S_WRITE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy             = busy_q;
  assign job_done         = job_done_q;
  assign found            = found_q;
  assign timeout_err      = timeout_q;
  assign aborted          = aborted_q;
  assign result_nonce     = result_nonce_q;
  assign result_hash      = result_hash_q;
  assign attempts         = attempts_q;
  assign eng_start        = eng_start_q;
  assign eng_message_addr = MSG_ADDR;
  assign eng_output_addr  = OUT_ADDR;
  assign mem_own          = mem_own_q;
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_write_data   = mem_wdata_q;

endmodule
